// File: rtl/pwm_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : pwm_unit_if
// Description : Shared unit-bus bundle between the host command parser and
//               an execution unit (argument stream, command, response, invol).
// Revision    : 1.0 - initial release
// ============================================================================
interface pwm_unit_if #(
    parameter int CMD_BITS = 3
);
    logic [31:0]         arg_data;
    logic                arg_advance;
    logic [CMD_BITS-1:0] cmd;
    logic                cmd_ready;
    logic                cmd_done;
    logic [31:0]         param_data;
    logic                param_write;
    logic                invol_req;
    logic                invol_grant;

    // Parser side
    modport master (
        output arg_data, cmd, cmd_ready, invol_grant,
        input  arg_advance, cmd_done, param_data, param_write, invol_req
    );

    // Execution-unit side
    modport slave (
        input  arg_data, cmd, cmd_ready, invol_grant,
        output arg_advance, cmd_done, param_data, param_write, invol_req
    );
endinterface
`default_nettype wire

// File: rtl/pwm_unit.sv
`default_nettype none
// ============================================================================
// Module      : pwm_unit
// Description : Command-driven bank of NPWM hardware PWM channels with
//               immediate, scheduled and time-limited duty updates.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_unit #(
    parameter int NPWM             = 12,
    parameter int CMD_BITS         = 3,
    parameter int CMD_CONFIG_PWM   = 5,
    parameter int CMD_SET_PWM      = 6,
    parameter int CMD_SCHEDULE_PWM = 7
) (
    input  wire logic            clk,
    input  wire logic            rst,
    input  wire logic [63:0]     systime,
    pwm_unit_if.slave            bus,
    output logic [NPWM-1:0]      pwm
);

    localparam logic [CMD_BITS-1:0] c_cmd_config = CMD_BITS'(CMD_CONFIG_PWM);
    localparam logic [CMD_BITS-1:0] c_cmd_set    = CMD_BITS'(CMD_SET_PWM);
    localparam logic [CMD_BITS-1:0] c_cmd_sched  = CMD_BITS'(CMD_SCHEDULE_PWM);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ARGS = 2'd1;
    localparam logic [1:0] S_EXEC = 2'd2;

    logic [1:0]          r_state;
    logic [CMD_BITS-1:0] r_cmd;
    logic [2:0]          r_idx;
    logic [2:0]          r_remain;
    logic                r_cmd_done;
    logic [31:0]         r_args [5];

    logic [2:0]          w_cmd_nargs;
    logic                w_arg_advance;
    logic                w_exec;
    logic                w_do_config;
    logic                w_do_set;
    logic                w_do_sched;
    logic                w_unused_ok;

    always_comb begin
        w_cmd_nargs = 3'd0;
        if (bus.cmd == c_cmd_config) begin
            w_cmd_nargs = 3'd5;
        end else if (bus.cmd == c_cmd_set) begin
            w_cmd_nargs = 3'd2;
        end else if (bus.cmd == c_cmd_sched) begin
            w_cmd_nargs = 3'd3;
        end
    end

    // Advance must coincide with the capture cycle, so it cannot be registered.
    assign w_arg_advance = ((r_state == S_IDLE) && bus.cmd_ready && (w_cmd_nargs > 3'd1)) ||
                           ((r_state == S_ARGS) && (r_remain > 3'd1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cmd      <= '0;
            r_idx      <= 3'd0;
            r_remain   <= 3'd0;
            r_cmd_done <= 1'b0;
            for (int k = 0; k < 5; k++) begin
                r_args[k] <= 32'd0;
            end
        end else begin
            r_cmd_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.cmd_ready) begin
                        r_cmd     <= bus.cmd;
                        r_args[0] <= bus.arg_data;
                        r_idx     <= 3'd1;
                        if (w_cmd_nargs > 3'd1) begin
                            r_remain <= w_cmd_nargs - 3'd1;
                            r_state  <= S_ARGS;
                        end else begin
                            r_remain   <= 3'd0;
                            r_state    <= S_EXEC;
                            r_cmd_done <= 1'b1;
                        end
                    end
                end
                S_ARGS: begin
                    r_args[r_idx] <= bus.arg_data;
                    r_idx         <= r_idx + 3'd1;
                    r_remain      <= r_remain - 3'd1;
                    if (r_remain == 3'd1) begin
                        r_state    <= S_EXEC;
                        r_cmd_done <= 1'b1;
                    end
                end
                S_EXEC: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign w_exec      = (r_state == S_EXEC);
    assign w_do_config = w_exec && (r_cmd == c_cmd_config);
    assign w_do_set    = w_exec && (r_cmd == c_cmd_set);
    assign w_do_sched  = w_exec && (r_cmd == c_cmd_sched);

    assign bus.arg_advance = w_arg_advance;
    assign bus.cmd_done    = r_cmd_done;
    assign bus.param_data  = 32'd0;
    assign bus.param_write = 1'b0;
    assign bus.invol_req   = 1'b0;

    assign w_unused_ok = ^{bus.invol_grant, systime[63:32]};

    for (genvar i = 0; i < NPWM; i++) begin : g_ch
        localparam logic [31:0] c_ch = 32'(i);

        logic [31:0] r_cycle_ticks;
        logic [31:0] r_value;
        logic [31:0] r_default;
        logic [31:0] r_max_dur;
        logic [31:0] r_sched_clock;
        logic [31:0] r_sched_value;
        logic [31:0] r_period;
        logic [31:0] r_dur;
        logic        r_pending;
        logic        r_pwm;

        logic        w_hit;
        logic [31:0] w_sched_delta;
        logic        w_sched_due;

        assign w_hit         = (r_args[0] == c_ch);
        assign w_sched_delta = systime[31:0] - r_sched_clock;
        // Signed difference >= 0 keeps working across systime wrap.
        assign w_sched_due   = r_pending && !w_sched_delta[31];

        always_ff @(posedge clk) begin
            if (rst) begin
                r_cycle_ticks <= 32'd0;
                r_value       <= 32'd0;
                r_default     <= 32'd0;
                r_max_dur     <= 32'd0;
                r_sched_clock <= 32'd0;
                r_sched_value <= 32'd0;
                r_period      <= 32'd0;
                r_dur         <= 32'd0;
                r_pending     <= 1'b0;
                r_pwm         <= 1'b0;
            end else begin
                if (w_do_config && w_hit) begin
                    r_cycle_ticks <= r_args[1];
                    r_value       <= r_args[2];
                    r_default     <= r_args[3];
                    r_max_dur     <= r_args[4];
                    r_pending     <= 1'b0;
                    r_period      <= 32'd0;
                    r_dur         <= 32'd0;
                end else begin
                    if ((r_cycle_ticks == 32'd0) || (r_period >= r_cycle_ticks - 32'd1)) begin
                        r_period <= 32'd0;
                    end else begin
                        r_period <= r_period + 32'd1;
                    end

                    if (w_do_set && w_hit) begin
                        r_value <= r_args[1];
                        r_dur   <= 32'd0;
                        if (w_sched_due) begin
                            r_pending <= 1'b0;
                        end
                    end else if (w_sched_due) begin
                        r_value   <= r_sched_value;
                        r_pending <= 1'b0;
                        r_dur     <= 32'd0;
                    end else if ((r_max_dur != 32'd0) && (r_value != r_default)) begin
                        if (r_dur + 32'd1 == r_max_dur) begin
                            r_value <= r_default;
                            r_dur   <= 32'd0;
                        end else begin
                            r_dur <= r_dur + 32'd1;
                        end
                    end

                    // A fresh schedule replaces whatever was pending.
                    if (w_do_sched && w_hit) begin
                        r_pending     <= 1'b1;
                        r_sched_clock <= r_args[1];
                        r_sched_value <= r_args[2];
                    end
                end
                r_pwm <= (r_cycle_ticks != 32'd0) && (r_period < r_value);
            end
        end

        assign pwm[i] = r_pwm;
    end

endmodule
`default_nettype wire

// File: tb/tb_pwm_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pwm_unit
// Description : Directed, table-driven self-checking bench for pwm_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_unit;

    localparam int NPWM = 12;

    typedef struct {
        logic [2:0]       cmd;
        logic [4:0][31:0] a;
        logic [7:0]       exp_adv;
        int               exp_done;
        int               exp_high;
    } vec_t;

    logic            clk;
    logic            rst;
    logic [63:0]     systime;
    logic [NPWM-1:0] pwm;

    int n_checks;
    int n_fail;
    int n_viol;

    pwm_unit_if #(.CMD_BITS(3)) bus ();

    pwm_unit dut (
        .clk     (clk),
        .rst     (rst),
        .systime (systime),
        .bus     (bus.slave),
        .pwm     (pwm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) systime <= 64'd0;
        else     systime <= systime + 64'd1;
    end

    always @(negedge clk) begin
        if (!rst && (bus.param_write || bus.invol_req || (bus.param_data != 32'd0)))
            n_viol++;
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d, expected %0d", name, act, exp);
        end
    endtask

    // Parser model: presents arg0 with cmd_ready, moves to the next arg after each advance.
    task automatic run_cmd(input logic [2:0] c, input logic [4:0][31:0] a,
                           output logic [7:0] adv_mask, output int done_at);
        int idx;
        idx      = 0;
        adv_mask = 8'h00;
        done_at  = -1;
        @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            bus.cmd_ready = (k == 0);
            bus.cmd       = c;
            bus.arg_data  = a[idx];
            #1;
            if (bus.arg_advance) begin
                adv_mask[k] = 1'b1;
                if (idx < 4) idx++;
            end
            if (bus.cmd_done && done_at < 0) done_at = k;
            @(negedge clk);
            if (done_at >= 0) break;
        end
        bus.cmd_ready = 1'b0;
    endtask

    task automatic sample_window(input int ch, input int n, input logic [NPWM-1:0] keep,
                                 output int hi, output int longest, output logic [NPWM-1:0] others);
        int run;
        hi = 0; longest = 0; run = 0; others = '0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            #1;
            if (pwm[ch]) begin
                hi++;
                run++;
                if (run > longest) longest = run;
            end else begin
                run = 0;
            end
            others = others | (pwm & ~keep);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] c, input logic [31:0] a0, input logic [31:0] a1,
                                input logic [31:0] a2, input logic [31:0] a3, input logic [31:0] a4,
                                input logic [7:0] adv, input int done, input int high);
        vec_t v;
        v.cmd      = c;
        v.a        = {a4, a3, a2, a1, a0};
        v.exp_adv  = adv;
        v.exp_done = done;
        v.exp_high = high;
        return v;
    endfunction

    vec_t            vecs [7];
    logic [7:0]      adv;
    int              done_at;
    int              hi;
    int              longest;
    logic [NPWM-1:0] others;
    logic [31:0]     cl;
    logic [4:0][31:0] args;

    initial begin
        n_checks = 0; n_fail = 0; n_viol = 0;
        rst = 1'b1;
        bus.cmd_ready   = 1'b0;
        bus.cmd         = 3'd0;
        bus.arg_data    = 32'd0;
        bus.invol_grant = 1'b0;

        // Channel 2 is the table's subject; every entry expects a 10-cycle period.
        vecs[0] = mk(3'd5, 32'd2,  32'd10, 32'd3, 32'd0, 32'd0, 8'h0F, 5, 30);
        vecs[1] = mk(3'd6, 32'd2,  32'd10, 32'd0, 32'd0, 32'd0, 8'h01, 2, 100);
        vecs[2] = mk(3'd6, 32'd2,  32'd0,  32'd0, 32'd0, 32'd0, 8'h01, 2, 0);
        vecs[3] = mk(3'd6, 32'd2,  32'd3,  32'd0, 32'd0, 32'd0, 8'h01, 2, 30);
        vecs[4] = mk(3'd3, 32'd2,  32'd9,  32'd0, 32'd0, 32'd0, 8'h00, 1, 30);
        vecs[5] = mk(3'd5, 32'd15, 32'd8,  32'd8, 32'd0, 32'd0, 8'h0F, 5, 30);
        vecs[6] = mk(3'd6, 32'd12, 32'd5,  32'd0, 32'd0, 32'd0, 8'h01, 2, 30);

        repeat (3) @(negedge clk);
        #1;
        check("reset_pwm", longint'(pwm), 0);
        check("reset_cmd_done", longint'(bus.cmd_done), 0);
        check("reset_arg_advance", longint'(bus.arg_advance), 0);
        rst = 1'b0;
        sample_window(0, 100, '0, hi, longest, others);
        check("idle_pwm_100", longint'(others), 0);

        for (int v = 0; v < 7; v++) begin
            run_cmd(vecs[v].cmd, vecs[v].a, adv, done_at);
            check($sformatf("vec%0d_adv", v), longint'(adv), longint'(vecs[v].exp_adv));
            check($sformatf("vec%0d_done", v), done_at, vecs[v].exp_done);
            sample_window(2, 3, 12'h004, hi, longest, others);
            sample_window(2, 100, 12'h004, hi, longest, others);
            check($sformatf("vec%0d_high", v), hi, vecs[v].exp_high);
            check($sformatf("vec%0d_others", v), longint'(others), 0);
        end

        // Future schedule: old 3/10 duty holds, then 5/10 once systime reaches the clock.
        cl   = systime[31:0] + 32'd50;
        args = {32'd0, 32'd0, 32'd5, cl, 32'd2};
        run_cmd(3'd7, args, adv, done_at);
        check("sched_adv", longint'(adv), 8'h03);
        check("sched_done", done_at, 3);
        sample_window(2, 30, 12'h004, hi, longest, others);
        check("sched_before", hi, 9);
        sample_window(2, 20, 12'h004, hi, longest, others);
        sample_window(2, 100, 12'h004, hi, longest, others);
        check("sched_after", hi, 50);

        // Past clock applies straight away.
        cl   = systime[31:0] - 32'd100;
        args = {32'd0, 32'd0, 32'd7, cl, 32'd2};
        run_cmd(3'd7, args, adv, done_at);
        sample_window(2, 3, 12'h004, hi, longest, others);
        sample_window(2, 100, 12'h004, hi, longest, others);
        check("sched_past", hi, 70);

        // Second schedule overwrites the first before it fires.
        cl   = systime[31:0] + 32'd40;
        args = {32'd0, 32'd0, 32'd9, cl, 32'd2};
        run_cmd(3'd7, args, adv, done_at);
        args = {32'd0, 32'd0, 32'd1, cl, 32'd2};
        run_cmd(3'd7, args, adv, done_at);
        sample_window(2, 60, 12'h004, hi, longest, others);
        sample_window(2, 100, 12'h004, hi, longest, others);
        check("sched_overwrite", hi, 10);

        // Timeout: 8/8 for max_duration cycles, then default 2/8.
        args = {32'd20, 32'd2, 32'd8, 32'd8, 32'd1};
        run_cmd(3'd5, args, adv, done_at);
        check("maxdur_done", done_at, 5);
        sample_window(1, 60, 12'h006, hi, longest, others);
        check("maxdur_run", longest, 20);
        sample_window(1, 80, 12'h006, hi, longest, others);
        check("maxdur_default_duty", hi, 20);
        check("maxdur_others", longint'(others), 0);

        check("resp_invol_zero", n_viol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
